pipe_stall_ctrl: RTL and testbench

//  Consumer end of the hazard-unit interface for the 5-stage MIPS pipeline (IF/ID/IE/IM/IWB).

---
 rtl/pipe_ctrl_pkg.sv | 35 +++
 rtl/pipe_stall_ctrl_if.sv | 36 +++
 rtl/pipe_perf_cnt.sv | 23 ++
 rtl/pipe_stall_ctrl.sv | 116 +++++++++++
 tb/tb_pipe_stall_ctrl.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline stall/flush controller: FSM state encoding and
// the bundle of per-stage stall/flush enables.
package pipe_ctrl_pkg;

  localparam int unsigned STATE_W = 2;

  // Encoding 2'd3 is unused and treated as ERR by the controller.
  typedef enum logic [STATE_W-1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERR      = 2'd2
  } pipe_state_t;

  typedef struct packed {
    logic stall_if;
    logic stall_id;
    logic flush_id;
    logic flush_ie;
    logic stall_ie;
    logic stall_im;
    logic bubble_iwb;
  } stage_ctrl_t;

  // Whole pipeline held and IWB write suppressed; used for memory freeze and ERR.
  localparam stage_ctrl_t CTRL_FREEZE = '{
    stall_if:   1'b1,
    stall_id:   1'b1,
    flush_id:   1'b0,
    flush_ie:   1'b0,
    stall_ie:   1'b1,
    stall_im:   1'b1,
    bubble_iwb: 1'b1
  };

endpackage

// File: rtl/pipe_stall_ctrl_if.sv
// Hazard/dmem request side and stage-enable side of the pipeline stall controller.
// master = hazard unit / datapath driving requests, slave = pipe_stall_ctrl.
interface pipe_stall_ctrl_if #(
  parameter int unsigned CNT_W = 32
);
  import pipe_ctrl_pkg::*;

  logic                is_hazy_i;
  logic                pc_src_id_i;
  logic                dmem_req_im_i;
  logic                dmem_ack_i;
  logic                stall_if_o;
  logic                stall_id_o;
  logic                flush_id_o;
  logic                flush_ie_o;
  logic                stall_ie_o;
  logic                stall_im_o;
  logic                bubble_iwb_o;
  logic                timeout_err_o;
  logic [STATE_W-1:0]  state_o;
  logic [CNT_W-1:0]    stall_cycles_o;
  logic [CNT_W-1:0]    mem_wait_cycles_o;

  modport master (
    output is_hazy_i, pc_src_id_i, dmem_req_im_i, dmem_ack_i,
    input  stall_if_o, stall_id_o, flush_id_o, flush_ie_o, stall_ie_o, stall_im_o,
    input  bubble_iwb_o, timeout_err_o, state_o, stall_cycles_o, mem_wait_cycles_o
  );

  modport slave (
    input  is_hazy_i, pc_src_id_i, dmem_req_im_i, dmem_ack_i,
    output stall_if_o, stall_id_o, flush_id_o, flush_ie_o, stall_ie_o, stall_im_o,
    output bubble_iwb_o, timeout_err_o, state_o, stall_cycles_o, mem_wait_cycles_o
  );

endinterface

// File: rtl/pipe_perf_cnt.sv
// Saturating event counter with synchronous active-low reset.
module pipe_perf_cnt #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (inc_i && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Per-stage stall/flush generation for the 5-stage pipeline with a dmem-wait FSM and
// timeout watchdog. Define PIPE_PERF_CNT_EN to build the stall/mem-wait perf counters.
module pipe_stall_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned CNT_W       = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  pipe_stall_ctrl_if.slave  ctrl_io
);

  localparam int unsigned  WaitW    = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WaitW-1:0] WaitLast = WaitW'(MEM_TIMEOUT - 1);

  pipe_state_t      state_q;
  logic [WaitW-1:0] wait_cnt_q;
  logic             timeout_err_q;
  logic             is_err;
  logic             freeze;
  stage_ctrl_t      ctrl;

  assign is_err = (state_q != RUN) && (state_q != MEM_WAIT);
  assign freeze = !is_err && ctrl_io.dmem_req_im_i && !ctrl_io.dmem_ack_i;

  // wait_cnt holds the number of freeze cycles already completed in this wait.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= RUN;
      wait_cnt_q    <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      unique case (state_q)
        RUN: begin
          if (freeze) begin
            state_q    <= MEM_WAIT;
            wait_cnt_q <= WaitW'(1);
          end
        end
        MEM_WAIT: begin
          if (!freeze) begin
            state_q    <= RUN;
            wait_cnt_q <= '0;
          end else begin
            wait_cnt_q <= wait_cnt_q + WaitW'(1);
            if (wait_cnt_q == WaitLast) begin
              state_q       <= ERR;
              timeout_err_q <= 1'b1;
            end
          end
        end
        default: begin
          state_q       <= ERR;
          timeout_err_q <= 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    ctrl = '0;
    if (is_err || freeze) begin
      ctrl = CTRL_FREEZE;
    end else begin
      ctrl.stall_if = ctrl_io.is_hazy_i;
      ctrl.stall_id = ctrl_io.is_hazy_i;
      ctrl.flush_ie = ctrl_io.is_hazy_i;
      // A branch held by a hazard stall flushes once the stall clears.
      ctrl.flush_id = ctrl_io.pc_src_id_i && !ctrl_io.is_hazy_i;
    end
  end

  assign ctrl_io.stall_if_o    = ctrl.stall_if;
  assign ctrl_io.stall_id_o    = ctrl.stall_id;
  assign ctrl_io.flush_id_o    = ctrl.flush_id;
  assign ctrl_io.flush_ie_o    = ctrl.flush_ie;
  assign ctrl_io.stall_ie_o    = ctrl.stall_ie;
  assign ctrl_io.stall_im_o    = ctrl.stall_im;
  assign ctrl_io.bubble_iwb_o  = ctrl.bubble_iwb;
  assign ctrl_io.timeout_err_o = timeout_err_q || is_err;
  assign ctrl_io.state_o       = state_q;

`ifdef PIPE_PERF_CNT_EN
  logic             hazard_stall;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] mem_wait_cycles;

  assign hazard_stall = !is_err && !freeze && ctrl_io.is_hazy_i;

  pipe_perf_cnt #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc_i (hazard_stall),
    .cnt_o (stall_cycles)
  );

  pipe_perf_cnt #(
    .CNT_W (CNT_W)
  ) u_mem_wait_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc_i (freeze),
    .cnt_o (mem_wait_cycles)
  );

  assign ctrl_io.stall_cycles_o    = stall_cycles;
  assign ctrl_io.mem_wait_cycles_o = mem_wait_cycles;
`else
  assign ctrl_io.stall_cycles_o    = {CNT_W{1'b0}};
  assign ctrl_io.mem_wait_cycles_o = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Self-checking bench for pipe_stall_ctrl: directed vector table, hand-written timeout and
// perf-counter sequences, and randomized traffic against a behavioural model.
module tb_pipe_stall_ctrl;

  localparam int unsigned MemTimeout = 8;
  localparam int unsigned CntW       = 4;
  localparam int          CntMax     = 15;
`ifdef PIPE_PERF_CNT_EN
  localparam bit PerfEn = 1'b1;
`else
  localparam bit PerfEn = 1'b0;
`endif

  localparam logic [6:0] CFrz = 7'b1100111;
  localparam logic [6:0] CHaz = 7'b1101000;
  localparam logic [6:0] CBr  = 7'b0010000;
  localparam logic [6:0] CIdl = 7'b0000000;

  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_err = 0;

  // Model state: consecutive freeze cycles completed, sticky error, perf counts.
  int m_len;
  bit m_err;
  int m_stall;
  int m_mem;

  always #5 clk = ~clk;

  pipe_stall_ctrl_if #(.CNT_W(CntW)) bus ();

  pipe_stall_ctrl #(
    .MEM_TIMEOUT (MemTimeout),
    .CNT_W       (CntW)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ctrl_io (bus.slave)
  );

  typedef struct {
    logic       hazy;
    logic       pc;
    logic       req;
    logic       ack;
    logic [6:0] ctrl;
    logic [1:0] st;
  } vec_t;

  vec_t vecs[16];

  function automatic logic [6:0] act_ctrl();
    return {bus.stall_if_o, bus.stall_id_o, bus.flush_id_o, bus.flush_ie_o,
            bus.stall_ie_o, bus.stall_im_o, bus.bubble_iwb_o};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic h, input logic p, input logic q,
                       input logic a);
    rst_n             = r;
    bus.is_hazy_i     = h;
    bus.pc_src_id_i   = p;
    bus.dmem_req_im_i = q;
    bus.dmem_ack_i    = a;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic m_clear();
    m_len   = 0;
    m_err   = 1'b0;
    m_stall = 0;
    m_mem   = 0;
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    m_clear();
  endtask

  function automatic bit m_frozen();
    return !m_err && bus.dmem_req_im_i && !bus.dmem_ack_i;
  endfunction

  function automatic logic [6:0] m_ctrl();
    logic h;
    logic p;
    h = bus.is_hazy_i;
    p = bus.pc_src_id_i;
    if (m_err || m_frozen()) return CFrz;
    return {h, h, p && !h, h, 3'b000};
  endfunction

  function automatic logic [1:0] m_state();
    if (m_err) return 2'd2;
    return (m_len > 0) ? 2'd1 : 2'd0;
  endfunction

  task automatic m_edge();
    bit fr;
    if (!rst_n) begin
      m_clear();
    end else begin
      fr = m_frozen();
      if (!m_err && !fr && bus.is_hazy_i && m_stall < CntMax) m_stall++;
      if (fr && m_mem < CntMax) m_mem++;
      if (fr) begin
        m_len++;
        if (m_len == MemTimeout) m_err = 1'b1;
      end else if (!m_err) begin
        m_len = 0;
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] exp_cnt;
    int          ack_pct;

    //           hazy  pc    req   ack   ctrl  state
    vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, CIdl, 2'd0};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, CHaz, 2'd0};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, CIdl, 2'd0};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, CBr,  2'd0};
    vecs[4]  = '{1'b1, 1'b1, 1'b0, 1'b0, CHaz, 2'd0};
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, CBr,  2'd0};
    vecs[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, CFrz, 2'd0};
    vecs[7]  = '{1'b1, 1'b0, 1'b1, 1'b0, CFrz, 2'd1};
    vecs[8]  = '{1'b0, 1'b1, 1'b1, 1'b0, CFrz, 2'd1};
    vecs[9]  = '{1'b1, 1'b0, 1'b1, 1'b1, CHaz, 2'd1};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b0, CIdl, 2'd0};
    vecs[11] = '{1'b0, 1'b0, 1'b1, 1'b1, CIdl, 2'd0};
    vecs[12] = '{1'b0, 1'b0, 1'b0, 1'b1, CIdl, 2'd0};
    vecs[13] = '{1'b0, 1'b0, 1'b1, 1'b0, CFrz, 2'd0};
    vecs[14] = '{1'b0, 1'b0, 1'b0, 1'b0, CIdl, 2'd1};
    vecs[15] = '{1'b0, 1'b0, 1'b0, 1'b0, CIdl, 2'd0};

    // Reset state
    do_reset();
    #1;
    check("reset ctrl", 32'(act_ctrl()), 32'(CIdl));
    check("reset state", 32'(bus.state_o), 32'd0);
    check("reset err", 32'(bus.timeout_err_o), 32'd0);
    check("reset stall_cnt", 32'(bus.stall_cycles_o), 32'd0);
    check("reset mem_cnt", 32'(bus.mem_wait_cycles_o), 32'd0);
    tick();

    // Directed vector table
    foreach (vecs[i]) begin
      drive(1'b1, vecs[i].hazy, vecs[i].pc, vecs[i].req, vecs[i].ack);
      #1;
      check($sformatf("vec%0d ctrl", i), 32'(act_ctrl()), 32'(vecs[i].ctrl));
      check($sformatf("vec%0d state", i), 32'(bus.state_o), 32'(vecs[i].st));
      check($sformatf("vec%0d err", i), 32'(bus.timeout_err_o), 32'd0);
      tick();
    end

    // Timeout: req held without ack for MemTimeout freeze cycles
    do_reset();
    for (int i = 0; i < int'(MemTimeout); i++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      #1;
      check($sformatf("tmo%0d state", i), 32'(bus.state_o), (i == 0) ? 32'd0 : 32'd1);
      check($sformatf("tmo%0d ctrl", i), 32'(act_ctrl()), 32'(CFrz));
      check($sformatf("tmo%0d err", i), 32'(bus.timeout_err_o), 32'd0);
      tick();
    end
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    #1;
    check("err state", 32'(bus.state_o), 32'd2);
    check("err flag", 32'(bus.timeout_err_o), 32'd1);
    check("err ctrl", 32'(act_ctrl()), 32'(CFrz));
    tick();
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    #1;
    check("err sticky state", 32'(bus.state_o), 32'd2);
    check("err sticky ctrl", 32'(act_ctrl()), 32'(CFrz));
    check("err mem_cnt frozen", 32'(bus.mem_wait_cycles_o), PerfEn ? 32'd8 : 32'd0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    check("post-err ctrl", 32'(act_ctrl()), 32'(CIdl));
    check("post-err state", 32'(bus.state_o), 32'd0);
    check("post-err flag", 32'(bus.timeout_err_o), 32'd0);
    tick();

    // Perf counters: hazard saturation, then a 5-cycle freeze
    do_reset();
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
    end
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    check("perf stall sat", 32'(bus.stall_cycles_o), PerfEn ? 32'd15 : 32'd0);
    check("perf mem idle", 32'(bus.mem_wait_cycles_o), 32'd0);
    do_reset();
    #1;
    check("perf stall cleared", 32'(bus.stall_cycles_o), 32'd0);
    tick();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
      tick();
    end
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    check("perf mem 5", 32'(bus.mem_wait_cycles_o), PerfEn ? 32'd5 : 32'd0);
    check("perf stall during freeze", 32'(bus.stall_cycles_o), 32'd0);
    check("perf freeze state", 32'(bus.state_o), 32'd0);
    tick();

    // Randomized traffic against the model
    ack_pct = 50;
    for (int i = 0; i < 2000; i++) begin
      if (i % 200 == 0) ack_pct = (ack_pct == 50) ? 5 : 50;
      drive((i == 0) ? 1'b0 : 1'($urandom_range(0, 149) != 0),
            1'($urandom_range(0, 2) == 0),
            1'($urandom_range(0, 2) == 0),
            1'($urandom_range(0, 1)),
            1'($urandom_range(0, 99) < ack_pct));
      #1;
      check($sformatf("rnd%0d ctrl", i), 32'(act_ctrl()), 32'(m_ctrl()));
      check($sformatf("rnd%0d state", i), 32'(bus.state_o), 32'(m_state()));
      check($sformatf("rnd%0d err", i), 32'(bus.timeout_err_o), 32'(m_err));
      exp_cnt = PerfEn ? 32'(m_stall) : 32'd0;
      check($sformatf("rnd%0d stall_cnt", i), 32'(bus.stall_cycles_o), exp_cnt);
      exp_cnt = PerfEn ? 32'(m_mem) : 32'd0;
      check($sformatf("rnd%0d mem_cnt", i), 32'(bus.mem_wait_cycles_o), exp_cnt);
      m_edge();
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
